seq_mult_ctrl: RTL

//   Iterative shift-add multiplier sequencer for the ALU datapath.

---
 rtl/seq_mult_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_mult_ctrl.sv
// Iterative shift-add multiplier: start accepted in IDLE/DONE, done pulses WIDTH+2 edges later.
// start is ignored while busy (no queueing); hi/lo hold the last product until the next result.
module seq_mult_ctrl #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (SIGNED && x[WIDTH-1]) begin
      return ~x + WIDTH'(1);
    end
    return x;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_hi_d = acc_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = '0;
    prod     = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Raw operands parked in mcand/mplier; magnitudes are taken in PREP.
          state_d  = S_PREP;
          mcand_d  = op1;
          mplier_d = op2;
          neg_d    = SIGNED & (op1[WIDTH-1] ^ op2[WIDTH-1]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        mcand_d  = mag(mcand_q);
        mplier_d = mag(mplier_q);
        acc_hi_d = '0;
        cnt_d    = '0;
        state_d  = S_ITER;
      end
      S_ITER: begin
        sum = {1'b0, acc_hi_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        {acc_hi_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        prod = {acc_hi_q, mplier_q};
        if (neg_q) begin
          prod = ~prod + PW'(1);
        end
        hi_d    = prod[PW-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_SIGN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
